channel_reduce_sched: RTL and testbench
=======================================

# channel_reduce_sched

Round-robin scheduler that shares one 32-bit reduce datapath (accumulate-then-emit) among NCH input ac_channel ports and one output ac_channel port. For each input channel it pops COUNT words, sums them into a per-channel accumulator, and writes the sum, tagged with the channel index, to the shared output channel. It sits between the HLS-generated channel FIFOs and downstream consumers. It replaces per-channel reduce instances with one arbitrated adder.

## Interface
- NCH, 4, number of input channels (2..8)
- WIDTH, 32, data width
- COUNT, 4, words reduced per channel per run (1..255)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run; ignored unless state is IDLE or DONE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE; held until next accepted start or rst
- in_out_data  in  NCH*WIDTH  channel c data at bits [c*WIDTH +: WIDTH]
- in_read_ready  in  NCH  channel c has a word available
- in_read_valid  out  NCH  one-hot pop strobe
- out_in_data  out  WIDTH  result word
- out_tag  out  clog2(NCH)  channel index of out_in_data
- out_write_valid  out  1  one-cycle write strobe
- out_write_ready  in  1  output channel can accept a word

## Operation
- States: IDLE, ARB, POP, CAP, WAIT_OUT, WRITE, DONE.
- On reset, state is IDLE. All outputs are 0. Accumulators, counters, finished mask and round-robin pointer are cleared. The pointer is set so channel 0 has first priority.
- IDLE/DONE + start: clear acc[], cnt[] and fin[], then go to ARB.
- ARB: eligible = in_read_ready & ~fin. Grant the first eligible channel at or after ptr, modulo NCH. If no channel is eligible, stay in ARB. On grant, latch g, set ptr=g+1 (wrapping), and go to POP.
- POP: in_read_valid[g]=1 for exactly this cycle. Go to CAP.
- CAP: sample in_out_data[g]. Set acc[g] to acc[g] plus the sample and increment cnt[g]. If the new cnt[g] equals COUNT, go to WAIT_OUT; otherwise go to ARB.
- WAIT_OUT: stay until out_write_ready=1, then go to WRITE.
- WRITE: drive out_write_valid=1, out_in_data=acc[g] and out_tag=g. Set fin[g] and clear acc[g]. If every fin bit is now set, go to DONE; otherwise go to ARB.
- Arithmetic: signed two's-complement, WIDTH bits. Overflow wraps modulo 2^WIDTH unless saturation is compiled in (see Configuration).
- Words from different channels interleave freely; each channel keeps its own accumulator.
- rst mid-run: the whole run is abandoned. A word already popped is lost. No output write is issued.

## Timing
- Per word: at least 3 cycles (ARB, POP, CAP) when read_ready is already high.
- Output: WAIT_OUT plus WRITE is at least 2 cycles after the final CAP.
- A full run with all inputs ready and the output always ready takes NCH*(3*COUNT+2) cycles from start to done.
- done rises on the cycle after the last WRITE.
- in_read_valid and out_write_valid are never asserted in the same cycle.
- in_read_valid and out_write_valid are registered-state decodes: they depend on state only, not combinationally on the ready inputs.
- read_ready may drop after the grant; the pop still occurs. The producer guarantees data stays valid until the pop.

## Configuration
- CHANNEL_REDUCE_SCHED_SAT_EN defined: the accumulate saturates to the signed limits. Positive overflow gives 2^(WIDTH-1)-1; negative overflow gives -2^(WIDTH-1).
- CHANNEL_REDUCE_SCHED_SAT_EN undefined: the accumulate wraps modulo 2^WIDTH.

## Structure
- Shared package channel_reduce_pkg holds:
  - the state enum;
  - default constants CR_NCH, CR_WIDTH and CR_COUNT;
  - the tag-width function.
- Sub-module channel_reduce_rr_arb: a combinational round-robin grant. Inputs are the request vector and ptr; outputs are a one-hot grant, the binary index and any_grant. It is reused elsewhere for FIFO sharing.
- The accumulator and counter arrays, and the FSM, live in channel_reduce_sched.

## Test plan
- NCH=4, COUNT=4, all read_ready=1, channel c supplies words c*10+1..c*10+4. Required results, in order with their tags:
  - tag 0, sum 10
  - tag 1, sum 50
  - tag 2, sum 90
  - tag 3, sum 130
  - done is asserted 56 cycles after start.
- Only channel 2 is ready, then channel 0 becomes ready after 3 pops. Required: channel 0 is granted next (round-robin from ptr=3 wraps). Interleaved sums stay correct per tag.
- out_write_ready held at 0 for 20 cycles after channel 0 completes. Required: state stays in WAIT_OUT, with no pops and no write. The write of 10/tag 0 occurs 1 cycle after ready rises.
- Channel 1 supplies 0x7FFFFFFF and then 1, 0, 0. Required output is 0x80000000 without the macro and 0x7FFFFFFF with CHANNEL_REDUCE_SCHED_SAT_EN.
- rst asserted during CAP of the second channel. Required: the next cycle shows all outputs 0 and state IDLE. A fresh start gives correct sums from a zeroed state.
- start pulsed while busy. Required: it is ignored, and results match an undisturbed run.

Source files
------------

// File: rtl/channel_reduce_pkg.sv
// Shared types and defaults for the channel reduce scheduler: FSM state
// encoding, default geometry and the tag-width helper.
package channel_reduce_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    POP,
    CAP,
    WAIT_OUT,
    WRITE,
    DONE
  } cr_state_e;

  localparam int CR_NCH   = 4;
  localparam int CR_WIDTH = 32;
  localparam int CR_COUNT = 4;

  // Width of a channel index; never narrower than one bit.
  function automatic int cr_tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/channel_reduce_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (modulo N). Also used for FIFO sharing elsewhere.
module channel_reduce_rr_arb
  import channel_reduce_pkg::*;
#(
  parameter int N  = CR_NCH,
  parameter int IW = cr_tag_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any_gnt && req[j]) begin
        any_gnt = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/channel_reduce_sched.sv
// Round-robin scheduler sharing one accumulate-then-emit adder among NCH input
// channels. Define CHANNEL_REDUCE_SCHED_SAT_EN for a saturating accumulate.
module channel_reduce_sched
  import channel_reduce_pkg::*;
#(
  parameter int NCH   = CR_NCH,
  parameter int WIDTH = CR_WIDTH,
  parameter int COUNT = CR_COUNT,
  localparam int TW   = cr_tag_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic [NCH*WIDTH-1:0] in_out_data,
  input  logic [NCH-1:0]       in_read_ready,
  output logic [NCH-1:0]       in_read_valid,
  output logic [WIDTH-1:0]     out_in_data,
  output logic [TW-1:0]        out_tag,
  output logic                 out_write_valid,
  input  logic                 out_write_ready
);

  localparam logic [7:0] COUNT_L = 8'(COUNT);

  cr_state_e        state, state_nxt;
  logic [WIDTH-1:0] acc [NCH];
  logic [7:0]       cnt [NCH];
  logic [NCH-1:0]   fin, fin_set, g_oh, eligible, arb_gnt;
  logic [TW-1:0]    ptr, g, arb_idx;
  logic             arb_any;
  logic [WIDTH-1:0] sample, sum_wrap, sum;
  logic [7:0]       cnt_inc;

  assign eligible = in_read_ready & ~fin;

  channel_reduce_rr_arb #(.N(NCH), .IW(TW)) u_arb (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  assign sample   = in_out_data[int'(g)*WIDTH +: WIDTH];
  assign sum_wrap = acc[g] + sample;
  assign cnt_inc  = cnt[g] + 8'd1;
  assign fin_set  = fin | g_oh;

`ifdef CHANNEL_REDUCE_SCHED_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow only when both operands share a sign the result lacks.
  always_comb begin
    sum = sum_wrap;
    if ((acc[g][WIDTH-1] == sample[WIDTH-1]) && (sum_wrap[WIDTH-1] != sample[WIDTH-1]))
      sum = sample[WIDTH-1] ? SMIN : SMAX;
  end
`else
  assign sum = sum_wrap;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = ARB;
      ARB:        if (arb_any) state_nxt = POP;
      POP:        state_nxt = CAP;
      CAP:        state_nxt = (cnt_inc == COUNT_L) ? WAIT_OUT : ARB;
      WAIT_OUT:   if (out_write_ready) state_nxt = WRITE;
      WRITE:      state_nxt = (&fin_set) ? DONE : ARB;
      default:    state_nxt = IDLE;
    endcase
  end

  // Strobes decode registered state only, never the ready inputs.
  assign busy            = !((state == IDLE) || (state == DONE));
  assign done            = (state == DONE);
  assign in_read_valid   = (state == POP) ? g_oh : '0;
  assign out_write_valid = (state == WRITE);
  assign out_in_data     = (state == WRITE) ? acc[g] : '0;
  assign out_tag         = (state == WRITE) ? g : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      g_oh  <= '0;
      fin   <= '0;
      // NOTE: acc/cnt are small flop arrays, so they are cleared in reset; a
      // RAM-mapped array could not be cleared like this.
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            fin <= '0;
            for (int i = 0; i < NCH; i++) begin
              acc[i] <= '0;
              cnt[i] <= '0;
            end
          end
        end
        ARB: begin
          if (arb_any) begin
            g    <= arb_idx;
            g_oh <= arb_gnt;
            ptr  <= (arb_idx == TW'(NCH - 1)) ? '0 : arb_idx + TW'(1);
          end
        end
        CAP: begin
          acc[g] <= sum;
          cnt[g] <= cnt_inc;
        end
        WRITE: begin
          fin    <= fin_set;
          acc[g] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_reduce_sched.sv
// Directed self-checking bench for channel_reduce_sched (NCH=4, COUNT=4);
// expectations follow CHANNEL_REDUCE_SCHED_SAT_EN when it is defined.
module tb_channel_reduce_sched;
  import channel_reduce_pkg::*;

  localparam int NCH   = 4;
  localparam int WIDTH = 32;
  localparam int COUNT = 4;
  localparam int TW    = cr_tag_w(NCH);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 out_write_ready = 1'b1;
  logic                 busy, done, out_write_valid;
  logic [NCH*WIDTH-1:0] in_out_data;
  logic [NCH-1:0]       in_read_ready, in_read_valid;
  logic [WIDTH-1:0]     out_in_data;
  logic [TW-1:0]        out_tag;

  logic [WIDTH-1:0] words [NCH][COUNT];
  bit               en [NCH];
  int               idx [NCH];
  bit               pend [NCH];
  bit               adv [NCH];
  int               res_tag [$];
  logic [WIDTH-1:0] res_data [$];
  int               pop_log [$];
  int               overlap = 0;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  channel_reduce_sched #(.NCH(NCH), .WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .in_out_data     (in_out_data),
    .in_read_ready   (in_read_ready),
    .in_read_valid   (in_read_valid),
    .out_in_data     (out_in_data),
    .out_tag         (out_tag),
    .out_write_valid (out_write_valid),
    .out_write_ready (out_write_ready)
  );

  // Producer channels: head word stays put through CAP, advances afterwards.
  always_comb begin
    in_read_ready = '0;
    in_out_data   = '0;
    for (int c = 0; c < NCH; c++) begin
      in_read_ready[c] = en[c] && (idx[c] < COUNT);
      if (idx[c] < COUNT) in_out_data[c*WIDTH +: WIDTH] = words[c][idx[c]];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        idx[c]  <= 0;
        pend[c] <= 1'b0;
        adv[c]  <= 1'b0;
      end
      res_tag.delete();
      res_data.delete();
      pop_log.delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (adv[c]) idx[c] <= idx[c] + 1;
        adv[c]  <= pend[c];
        pend[c] <= in_read_valid[c];
        if (in_read_valid[c]) pop_log.push_back(c);
      end
      if (out_write_valid) begin
        res_tag.push_back(int'(out_tag));
        res_data.push_back(out_in_data);
      end
      if ((|in_read_valid) && out_write_valid) overlap <= overlap + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_default();
    for (int c = 0; c < NCH; c++) begin
      en[c] = 1'b1;
      for (int k = 0; k < COUNT; k++) words[c][k] = 32'(c*10 + k + 1);
    end
  endtask

  task automatic start_and_wait(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  function automatic int find_result(input int c, output logic [WIDTH-1:0] d);
    int found = 0;
    d = 'x;
    foreach (res_tag[i]) if (res_tag[i] == c) begin
      found++;
      d = res_data[i];
    end
    return found;
  endfunction

  function automatic int count_pops(input int c);
    int k = 0;
    foreach (pop_log[i]) if (pop_log[i] == c) k++;
    return k;
  endfunction

  task automatic test_reset();
    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (in_read_valid !== '0) begin errors++; $display("FAIL reset_read_valid: got %b want 0", in_read_valid); end
    checks++; if (out_write_valid !== 1'b0) begin errors++; $display("FAIL reset_write_valid: got %b want 0", out_write_valid); end
    checks++; if (out_in_data !== '0 || out_tag !== '0) begin errors++; $display("FAIL reset_out: got %h/%0d want 0/0", out_in_data, out_tag); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    rst = 1'b0;
  endtask

  task automatic test_full_run();
    int n;
    logic [WIDTH-1:0] exp_sum [NCH] = '{32'd10, 32'd50, 32'd90, 32'd130};
    load_default();
    out_write_ready = 1'b1;
    do_reset();
    start_and_wait(n);
    checks++; if (n != 56) begin errors++; $display("FAIL full_latency: got %0d cycles want 56", n); end
    checks++; if (res_data.size() != NCH) begin errors++; $display("FAIL full_count: got %0d results want 4", res_data.size()); end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (i >= res_data.size() || res_tag[i] != i || res_data[i] !== exp_sum[i]) begin
        errors++;
        $display("FAIL full_result%0d: got tag %0d sum %0d want tag %0d sum %0d", i,
                 (i < res_tag.size()) ? res_tag[i] : -1, (i < res_data.size()) ? res_data[i] : 'x, i, exp_sum[i]);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (i >= pop_log.size() || pop_log[i] != i) begin
        errors++;
        $display("FAIL full_pop_order%0d: got %0d want %0d", i, (i < pop_log.size()) ? pop_log[i] : -1, i);
      end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_held: got done %b busy %b want 1 0", done, busy); end
  endtask

  task automatic test_rr_wrap();
    int n, cnt;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_sum [NCH] = '{32'd26, 32'd1000, 32'hFFFF_FFF6, 32'd4};
    for (int k = 0; k < COUNT; k++) begin
      words[0][k] = 32'(k + 5);
      words[1][k] = 32'((k + 1) * 100);
      words[2][k] = 32'(-(k + 1));
      words[3][k] = 32'd1;
    end
    en = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (pop_log.size() < 3 && n < 200) begin tick(); n++; end
    checks++;
    if (pop_log.size() < 3 || pop_log[0] != 2 || pop_log[1] != 2 || pop_log[2] != 2) begin
      errors++;
      $display("FAIL rr_only_ch2: got %0d pops (first %0d) want 3 pops of channel 2", pop_log.size(),
               (pop_log.size() > 0) ? pop_log[0] : -1);
    end
    en[0] = 1'b1;
    n = 0;
    while (pop_log.size() < 4 && n < 200) begin tick(); n++; end
    checks++;
    if (pop_log.size() < 4 || pop_log[3] != 0) begin
      errors++;
      $display("FAIL rr_wrap_grant: got channel %0d want 0", (pop_log.size() > 3) ? pop_log[3] : -1);
    end
    en = '{1'b1, 1'b1, 1'b1, 1'b1};
    n = 0;
    while (!done && n < 1000) begin tick(); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_done: got %b want 1", done); end
    for (int c = 0; c < NCH; c++) begin
      cnt = find_result(c, d);
      checks++;
      if (cnt != 1 || d !== exp_sum[c]) begin
        errors++;
        $display("FAIL rr_sum_tag%0d: got %0d writes sum %h want 1 write sum %h", c, cnt, d, exp_sum[c]);
      end
    end
  endtask

  task automatic test_wait_out();
    int n, pops_before, writes;
    bit state_ok;
    load_default();
    out_write_ready = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (count_pops(0) < COUNT && n < 300) begin tick(); n++; end
    checks++; if (count_pops(0) != COUNT) begin errors++; $display("FAIL wait_ch0_pops: got %0d want %0d", count_pops(0), COUNT); end
    tick();
    pops_before = pop_log.size();
    writes = 0;
    state_ok = 1'b1;
    repeat (20) begin
      tick();
      if (out_write_valid) writes++;
      if (dut.state !== WAIT_OUT) state_ok = 1'b0;
    end
    checks++; if (writes != 0) begin errors++; $display("FAIL wait_no_write: got %0d writes want 0", writes); end
    checks++; if (pop_log.size() != pops_before) begin errors++; $display("FAIL wait_no_pop: got %0d pops want %0d", pop_log.size(), pops_before); end
    checks++; if (!state_ok) begin errors++; $display("FAIL wait_state: got %0d want WAIT_OUT held", dut.state); end
    out_write_ready = 1'b1;
    tick();
    checks++;
    if (out_write_valid !== 1'b1 || out_in_data !== 32'd10 || out_tag !== 2'd0) begin
      errors++;
      $display("FAIL wait_release_write: got valid %b sum %0d tag %0d want 1 10 0", out_write_valid, out_in_data, out_tag);
    end
    n = 0;
    while (!done && n < 1000) begin tick(); n++; end
    checks++; if (done !== 1'b1 || res_data.size() != NCH) begin errors++; $display("FAIL wait_finish: got done %b results %0d want 1 4", done, res_data.size()); end
  endtask

  task automatic test_overflow();
    int n, cnt;
    logic [WIDTH-1:0] d;
`ifdef CHANNEL_REDUCE_SCHED_SAT_EN
    logic [WIDTH-1:0] exp_sum [NCH] = '{32'd10, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000};
`else
    logic [WIDTH-1:0] exp_sum [NCH] = '{32'd10, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF};
`endif
    words[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
    words[1] = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0};
    words[2] = '{32'd0, 32'd0, 32'd0, 32'd0};
    words[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0};
    en = '{1'b1, 1'b1, 1'b1, 1'b1};
    out_write_ready = 1'b1;
    do_reset();
    start_and_wait(n);
    checks++; if (n != 56) begin errors++; $display("FAIL ovf_latency: got %0d want 56", n); end
    for (int c = 0; c < NCH; c++) begin
      cnt = find_result(c, d);
      checks++;
      if (cnt != 1 || d !== exp_sum[c]) begin
        errors++;
        $display("FAIL ovf_sum_tag%0d: got %0d writes sum %h want 1 write sum %h", c, cnt, d, exp_sum[c]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    logic [WIDTH-1:0] exp_sum [NCH] = '{32'd10, 32'd50, 32'd90, 32'd130};
    load_default();
    out_write_ready = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (pop_log.size() < 2 && n < 100) begin tick(); n++; end
    checks++; if (pop_log.size() < 2 || pop_log[1] != 1) begin errors++; $display("FAIL rstmid_second_pop: got %0d pops want channel 1 second", pop_log.size()); end
    tick();
    checks++; if (dut.state !== CAP) begin errors++; $display("FAIL rstmid_in_cap: got %0d want CAP", dut.state); end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_read_valid !== '0 || out_write_valid !== 1'b0 ||
        out_in_data !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got busy %b done %b rv %b wv %b data %h tag %0d want all 0",
               busy, done, in_read_valid, out_write_valid, out_in_data, out_tag);
    end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state); end
    tick();
    rst = 1'b0;
    start_and_wait(n);
    checks++; if (n != 56) begin errors++; $display("FAIL rstmid_latency: got %0d want 56", n); end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (i >= res_data.size() || res_tag[i] != i || res_data[i] !== exp_sum[i]) begin
        errors++;
        $display("FAIL rstmid_result%0d: got sum %0d want %0d", i, (i < res_data.size()) ? res_data[i] : 'x, exp_sum[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    int n;
    logic [WIDTH-1:0] exp_sum [NCH] = '{32'd10, 32'd50, 32'd90, 32'd130};
    load_default();
    out_write_ready = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
      start = (n == 10 || n == 40);
    end
    start = 1'b0;
    checks++; if (n != 56 || done !== 1'b1) begin errors++; $display("FAIL busy_start_latency: got %0d want 56", n); end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (i >= res_data.size() || res_tag[i] != i || res_data[i] !== exp_sum[i]) begin
        errors++;
        $display("FAIL busy_start_result%0d: got sum %0d want %0d", i, (i < res_data.size()) ? res_data[i] : 'x, exp_sum[i]);
      end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL read_write_overlap: got %0d cycles want 0", overlap); end
  endtask

  initial begin
    load_default();
    test_reset();
    test_full_run();
    test_rr_wrap();
    test_wait_out();
    test_overflow();
    test_rst_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
